// File: rtl/roll_controller.sv
// Single-roll sequencer: captures entropy on request, reduces it modulo the die's
// side count with an 8-step shift-subtract loop, then holds the 1-based result until
// it is accepted. Optional feature macro: ROLL_TEST_EN (code 6 = deterministic D20).
module roll_controller #(
  parameter int unsigned RAND_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              roll_req,
  input  logic [2:0]        die_select,
  input  logic [RAND_W-1:0] rand_bits,
  output logic [4:0]        result,
  output logic [2:0]        result_die,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              roll_dropped
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [5:0]  rem_q, rem_d;
  logic [7:0]  byte_q, byte_d;
  logic [5:0]  sides_q, sides_d;
  logic [2:0]  die_q, die_d;
  logic [4:0]  result_q, result_d;
  logic [2:0]  result_die_q, result_die_d;
  logic        dropped_q, dropped_d;
`ifdef ROLL_TEST_EN
  logic [4:0]  test_cnt_q, test_cnt_d;
`endif

  logic        code_ok;
  logic [5:0]  code_sides;
  logic        bit_in;
  logic [5:0]  t;
  logic [5:0]  rem_next;
  logic        unused_rand;

  // Only the low byte of the entropy bus feeds the roll.
  assign unused_rand = ^rand_bits;

  always_comb begin
    code_ok    = 1'b1;
    code_sides = 6'd0;
    case (die_select)
      3'd0:    code_sides = 6'd4;
      3'd1:    code_sides = 6'd6;
      3'd2:    code_sides = 6'd8;
      3'd3:    code_sides = 6'd10;
      3'd4:    code_sides = 6'd12;
      3'd5:    code_sides = 6'd20;
`ifdef ROLL_TEST_EN
      3'd6:    code_sides = 6'd20;
`endif
      default: code_ok    = 1'b0;
    endcase
  end

  // One restoring-division step per cycle, byte consumed MSB first.
  always_comb begin
    bit_in   = byte_q[3'd7 - step_q];
    t        = {rem_q[4:0], bit_in};
    rem_next = (t >= sides_q) ? (t - sides_q) : t;
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    rem_d        = rem_q;
    byte_d       = byte_q;
    sides_d      = sides_q;
    die_d        = die_q;
    result_d     = result_q;
    result_die_d = result_die_q;
    dropped_d    = 1'b0;
`ifdef ROLL_TEST_EN
    test_cnt_d   = test_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (roll_req) begin
          if (code_ok) begin
            state_d = DIVIDE;
            sides_d = code_sides;
            die_d   = die_select;
            byte_d  = rand_bits[7:0];
            rem_d   = '0;
            step_d  = '0;
`ifdef ROLL_TEST_EN
            if (die_select == 3'd6) begin
              byte_d     = {3'b000, test_cnt_q};
              test_cnt_d = (test_cnt_q == 5'd19) ? 5'd0 : test_cnt_q + 5'd1;
            end
`endif
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      DIVIDE: begin
        dropped_d = roll_req;
        rem_d     = rem_next;
        step_d    = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d      = DONE;
          result_d     = rem_next[4:0] + 5'd1;
          result_die_d = die_q;
        end
      end
      DONE: begin
        dropped_d = roll_req;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      rem_q        <= '0;
      byte_q       <= '0;
      sides_q      <= '0;
      die_q        <= '0;
      result_q     <= '0;
      result_die_q <= '0;
      dropped_q    <= 1'b0;
`ifdef ROLL_TEST_EN
      test_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      rem_q        <= rem_d;
      byte_q       <= byte_d;
      sides_q      <= sides_d;
      die_q        <= die_d;
      result_q     <= result_d;
      result_die_q <= result_die_d;
      dropped_q    <= dropped_d;
`ifdef ROLL_TEST_EN
      test_cnt_q   <= test_cnt_d;
`endif
    end
  end

  assign result       = result_q;
  assign result_die   = result_die_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign roll_dropped = dropped_q;

endmodule

// File: tb/tb_roll_controller.sv
// Scoreboard bench for roll_controller: expected {die,result} pushed at request time,
// popped when result_valid appears.
module tb_roll_controller;

  localparam int unsigned RAND_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              roll_req;
  logic [2:0]        die_select;
  logic [RAND_W-1:0] rand_bits;
  logic [4:0]        result;
  logic [2:0]        result_die;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              roll_dropped;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  sb_q[$];

  roll_controller #(.RAND_W(RAND_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .roll_req     (roll_req),
    .die_select   (die_select),
    .rand_bits    (rand_bits),
    .result       (result),
    .result_die   (result_die),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .roll_dropped (roll_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] code, input logic [7:0] b);
    logic [7:0] hi;
    hi         = 8'($urandom_range(0, 255));
    roll_req   = 1'b1;
    die_select = code;
    rand_bits  = {hi, b};
  endtask

  // Issues a roll, measures latency to result_valid and checks the scoreboard head.
  task automatic roll_and_wait(input logic [2:0] code, input logic [7:0] b,
                               input logic [4:0] exp_res, input string name);
    int unsigned lat;
    logic [7:0]  exp;
    sb_q.push_back({code, exp_res});
    start_req(code, b);
    tick();
    roll_req = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy: got %b required 1", name, busy);
    end
    lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL %s_latency: got %0d required 8", name, lat);
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: got empty queue required entry", name);
    end else begin
      exp = sb_q.pop_front();
      if ({result_die, result} !== exp) begin
        bad++;
        $display("FAIL %s_result: got die=%0d res=%0d required die=%0d res=%0d",
                 name, result_die, result, exp[7:5], exp[4:0]);
      end
    end
  endtask

  task automatic handshake(input logic [4:0] exp_res, input string name);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    total++;
    if ({result_valid, busy, result} !== {1'b0, 1'b0, exp_res}) begin
      bad++;
      $display("FAIL %s_handshake: got valid=%b busy=%b res=%0d required 0 0 %0d",
               name, result_valid, busy, result, exp_res);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({result, result_die, result_valid, busy, roll_dropped} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state: got %h required 000", {result, result_die, result_valid, busy, roll_dropped});
    end
    reset_n = 1'b1;
    tick();
    total++;
    if ({result_valid, busy, roll_dropped} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release: got %b required 000", {result_valid, busy, roll_dropped});
    end
  endtask

  task automatic test_d6_ready_high();
    result_ready = 1'b1;
    roll_and_wait(3'd1, 8'hFF, 5'd4, "d6_ff");
    tick();
    total++;
    if ({result_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL d6_idle: got valid=%b busy=%b required 0 0", result_valid, busy);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_boundaries();
    roll_and_wait(3'd5, 8'h00, 5'd1,  "d20_00");
    handshake(5'd1, "d20_00");
    roll_and_wait(3'd0, 8'h07, 5'd4,  "d4_07");
    handshake(5'd4, "d4_07");
    roll_and_wait(3'd4, 8'hC8, 5'd9,  "d12_c8");
    handshake(5'd9, "d12_c8");
    roll_and_wait(3'd3, 8'h13, 5'd10, "d10_13");
    handshake(5'd10, "d10_13");
    roll_and_wait(3'd2, 8'h80, 5'd1,  "d8_80");
    handshake(5'd1, "d8_80");
  endtask

  task automatic test_backpressure();
    int unsigned drops;
    int unsigned busy_cnt;
    roll_and_wait(3'd3, 8'h13, 5'd10, "bp");
    drops = 0;
    for (int c = 0; c < 5; c++) begin
      roll_req   = (c == 0 || c == 2);
      die_select = 3'd5;
      tick();
      roll_req = 1'b0;
      if (roll_dropped === 1'b1) drops++;
      total++;
      if ({result_valid, result_die, result} !== {1'b1, 3'd3, 5'd10}) begin
        bad++;
        $display("FAIL bp_stable: got valid=%b die=%0d res=%0d required 1 3 10",
                 result_valid, result_die, result);
      end
    end
    total++;
    if (drops !== 2) begin
      bad++;
      $display("FAIL bp_drops: got %0d required 2", drops);
    end
    handshake(5'd10, "bp");
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy === 1'b1 || result_valid === 1'b1) busy_cnt++;
    end
    total++;
    if (busy_cnt !== 0) begin
      bad++;
      $display("FAIL bp_no_second_roll: got %0d busy cycles required 0", busy_cnt);
    end
  endtask

  task automatic test_same_edge();
    roll_and_wait(3'd0, 8'h07, 5'd4, "same");
    result_ready = 1'b1;
    start_req(3'd1, 8'h05);
    tick();
    roll_req     = 1'b0;
    result_ready = 1'b0;
    total++;
    if ({result_valid, busy, roll_dropped} !== 3'b001) begin
      bad++;
      $display("FAIL same_edge: got valid=%b busy=%b drop=%b required 0 0 1",
               result_valid, busy, roll_dropped);
    end
  endtask

  task automatic test_drop_code(input logic [2:0] code, input string name);
    int unsigned seen;
    start_req(code, 8'h33);
    tick();
    roll_req = 1'b0;
    total++;
    if ({busy, roll_dropped} !== 2'b01) begin
      bad++;
      $display("FAIL %s_drop: got busy=%b drop=%b required 0 1", name, busy, roll_dropped);
    end
    tick();
    total++;
    if (roll_dropped !== 1'b0) begin
      bad++;
      $display("FAIL %s_drop_pulse: got %b required 0", name, roll_dropped);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (result_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL %s_no_result: got %0d active cycles required 0", name, seen);
    end
  endtask

  task automatic test_reset_mid_divide();
    start_req(3'd4, 8'hC8);
    tick();
    roll_req = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if ({result, result_die, result_valid, busy, roll_dropped} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset: got %h required 000", {result, result_die, result_valid, busy, roll_dropped});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    roll_and_wait(3'd2, 8'h0B, 5'd4, "post_reset_d8");
    handshake(5'd4, "post_reset_d8");
  endtask

  task automatic test_code6();
`ifdef ROLL_TEST_EN
    for (int i = 0; i < 21; i++) begin
      logic [4:0] e;
      e = 5'((i % 20) + 1);
      roll_and_wait(3'd6, 8'($urandom_range(0, 255)), e, "test6");
      handshake(e, "test6");
    end
`else
    test_drop_code(3'd6, "code6");
`endif
  endtask

  initial begin
    reset_n      = 1'b0;
    roll_req     = 1'b0;
    die_select   = 3'd0;
    rand_bits    = '0;
    result_ready = 1'b0;
    repeat (2) tick();
    test_reset();
    test_d6_ready_high();
    test_boundaries();
    test_backpressure();
    test_same_edge();
    test_drop_code(3'd7, "code7");
    test_reset_mid_divide();
    test_code6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
